// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer bundle: software restart request, per-domain acks, per-domain
// active-low resets and sequence status.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_DOM = 3
);
  localparam int unsigned ERR_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  logic               sw_rst_req;
  logic [NUM_DOM-1:0] dom_rdy;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               seq_done;
  logic               seq_err;
  logic [ERR_W-1:0]   err_dom;

  modport master (
    input  sw_rst_req, dom_rdy,
    output dom_rst_n, seq_done, seq_err, err_dom
  );

  modport slave (
    output sw_rst_req, dom_rdy,
    input  dom_rst_n, seq_done, seq_err, err_dom
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller: holds all domains in reset, then releases them
// one at a time in index order, waiting for each ack with a gap and a timeout.
module rst_seq_ctrl #(
  parameter int unsigned NUM_DOM  = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rst_seq_ctrl_if.master  bus
);
  localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  typedef enum logic [2:0] {
    ST_ASSERT, ST_RELEASE, ST_WAIT_ACK, ST_GAP, ST_DONE, ST_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] rst_n_q, rst_n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   errdom_q, errdom_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_ASSERT;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      errdom_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_n_q  <= rst_n_d;
      done_q   <= done_d;
      err_q    <= err_d;
      errdom_q <= errdom_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (bus.sw_rst_req) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // An ack on the timeout edge still counts as success.
          if (bus.dom_rdy[idx_q]) begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            state_d = ST_ERROR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_DOM - 1)) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ASSERT;
      endcase
    end
  end

  // Outputs are registered, so they are derived from the transition being taken.
  always_comb begin
    rst_n_d  = rst_n_q;
    errdom_d = errdom_q;
    if (state_q == ST_RELEASE) rst_n_d[idx_q] = 1'b1;
    if (state_d == ST_ASSERT || state_d == ST_ERROR) rst_n_d = '0;
    if (state_q == ST_WAIT_ACK && state_d == ST_ERROR) errdom_d = idx_q;
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERROR);
  end

  assign bus.dom_rst_n = rst_n_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_err   = err_q;
  assign bus.err_dom   = errdom_q;

endmodule
